// File: rtl/axi_stream_strip_header_pkg.sv
// Shared constants, FSM state encoding and byte-count helper for the
// AXI-Stream header stripper.
package axi_stream_strip_header_pkg;

  localparam int DEFAULT_DATA_WD = 32;
  localparam int MAX_BYTES       = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  function automatic int unsigned popcount(input logic [MAX_BYTES-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/axi_stream_byte_merge.sv
// Concatenates residual bytes with an input beat: the first beat-width of
// bytes forms the output beat, the overflow becomes the next residual.
module axi_stream_byte_merge
  import axi_stream_strip_header_pkg::*;
#(
  parameter int DATA_WD      = DEFAULT_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CW           = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic [DATA_WD-1:0] res_data,
  input  logic [CW-1:0]      res_bytes,
  input  logic [DATA_WD-1:0] in_data,
  input  logic [CW-1:0]      in_bytes,
  output logic [DATA_WD-1:0] out_data,
  output logic [DATA_WD-1:0] next_res
);

  logic [DATA_WD-1:0]   in_masked;
  logic [2*DATA_WD-1:0] cat;
  int unsigned          sh;

  always_comb begin
    in_masked = in_data & ~({DATA_WD{1'b1}} >> (8 * in_bytes));
    // Input bytes land directly after the res_bytes residual bytes.
    sh        = 8 * (DATA_BYTE_WD - 32'(res_bytes));
    cat       = {res_data, {DATA_WD{1'b0}}} | ({{DATA_WD{1'b0}}, in_masked} << sh);
    out_data  = cat[2*DATA_WD-1 -: DATA_WD];
    next_res  = cat[DATA_WD-1:0];
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes the first N bytes of each AXI-Stream packet (N from a per-packet
// strip descriptor) and repacks the remaining bytes into full beats.
module axi_stream_strip_header
  import axi_stream_strip_header_pkg::*;
#(
  parameter int DATA_WD      = DEFAULT_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [DATA_BYTE_WD-1:0] keep_strip,
  output logic                    ready_strip
);

  localparam int CW = $clog2(DATA_BYTE_WD + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTE_WD);

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           n_q, n_d, r_q, r_d;
  logic [DATA_WD-1:0]      res_q, res_d, data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    valid_q, valid_d, last_q, last_d;

  logic [CW-1:0]      k_in;
  logic [CW:0]        sum;
  logic               out_free, accept;
  logic [DATA_WD-1:0] merge_data, merge_res, head_data;

  assign out_free    = !valid_q || ready_out;
  assign ready_in    = ((state_q == ST_HEAD) || (state_q == ST_BODY)) && out_free;
  assign ready_strip = (state_q == ST_IDLE) && !rst;
  assign accept      = valid_in && ready_in;
  assign k_in        = CW'(popcount(MAX_BYTES'(keep_in)));
  assign sum         = {1'b0, r_q} + {1'b0, k_in};
  assign head_data   = (data_in & ~({DATA_WD{1'b1}} >> (8 * k_in))) << (8 * n_q);

  axi_stream_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CW           (CW)
  ) u_merge (
    .res_data  (res_q),
    .res_bytes (r_q),
    .in_data   (data_in),
    .in_bytes  (k_in),
    .out_data  (merge_data),
    .next_res  (merge_res)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    res_d   = res_q;
    valid_d = valid_q && !ready_out;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_strip) begin
          n_d     = CW'(popcount(MAX_BYTES'(keep_strip)));
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (accept) begin
          if (!last_in) begin
            res_d   = head_data;
            r_d     = FULL - n_q;
            state_d = ST_BODY;
          end else begin
            // A last beat no longer than the header drops the packet silently.
            if (k_in > n_q) begin
              valid_d = 1'b1;
              data_d  = head_data;
              keep_d  = ~({DATA_BYTE_WD{1'b1}} >> (k_in - n_q));
              last_d  = 1'b1;
            end
            state_d = ST_IDLE;
          end
        end
      end
      ST_BODY: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = merge_data;
          if (!last_in) begin
            keep_d = '1;
            last_d = 1'b0;
            res_d  = merge_res;
          end else if (sum <= {1'b0, FULL}) begin
            keep_d  = ~({DATA_BYTE_WD{1'b1}} >> sum);
            last_d  = 1'b1;
            res_d   = '0;
            r_d     = '0;
            state_d = ST_IDLE;
          end else begin
            keep_d  = '1;
            last_d  = 1'b0;
            res_d   = merge_res;
            r_d     = CW'(sum - {1'b0, FULL});
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d  = res_q;
          keep_d  = ~({DATA_BYTE_WD{1'b1}} >> r_q);
          last_d  = 1'b1;
          res_d   = '0;
          r_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r_q     <= r_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header: directed scenarios plus
// randomized packets checked against a byte-queue reference model.
module tb_axi_stream_strip_header;

  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, last_in, ready_in;
  logic [DW-1:0] data_in, data_out;
  logic [BW-1:0] keep_in, keep_out, keep_strip;
  logic          valid_out, last_out, ready_out;
  logic          valid_strip, ready_strip;

  int checks = 0;
  int errors = 0;
  bit bp_en  = 1'b0;

  logic [DW-1:0] cap_data[$], exp_data[$];
  logic [BW-1:0] cap_keep[$], exp_keep[$];
  logic          cap_last[$], exp_last[$];

  always #5 clk = ~clk;

  axi_stream_strip_header #(
    .DATA_WD      (DW),
    .DATA_BYTE_WD (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .keep_in     (keep_in),
    .last_in     (last_in),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .keep_out    (keep_out),
    .last_out    (last_out),
    .ready_out   (ready_out),
    .valid_strip (valid_strip),
    .keep_strip  (keep_strip),
    .ready_strip (ready_strip)
  );

  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      cap_data.push_back(data_out);
      cap_keep.push_back(keep_out);
      cap_last.push_back(last_out);
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) ready_out = ($urandom_range(0, 3) != 0);
  end

  task automatic clear_q();
    cap_data.delete(); cap_keep.delete(); cap_last.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
  endtask

  // Reference: drop N leading bytes, chunk the rest into left-aligned beats.
  task automatic model(input int unsigned n, input logic [7:0] b[$]);
    logic [7:0] rem[$];
    rem = b;
    for (int unsigned i = 0; i < n && rem.size() > 0; i++) void'(rem.pop_front());
    for (int unsigned i = 0; i < rem.size(); i += BW) begin
      logic [DW-1:0] d;
      logic [BW-1:0] k;
      d = '0;
      k = '0;
      for (int unsigned j = 0; j < BW; j++) begin
        if (i + j < rem.size()) begin
          d[DW-1-8*j -: 8] = rem[i+j];
          k[BW-1-j] = 1'b1;
        end
      end
      exp_data.push_back(d);
      exp_keep.push_back(k);
      exp_last.push_back(i + BW >= rem.size());
    end
  endtask

  task automatic send_desc(input logic [BW-1:0] mask);
    int unsigned t = 0;
    valid_strip = 1'b1;
    keep_strip  = mask;
    @(negedge clk);
    while (!ready_strip && t < 300) begin @(negedge clk); t++; end
    if (!ready_strip) begin
      checks++; errors++;
      $display("FAIL desc_timeout ready_strip=%b required 1", ready_strip);
    end
    @(posedge clk); #1;
    valid_strip = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
    int unsigned t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    @(negedge clk);
    while (!ready_in && t < 300) begin @(negedge clk); t++; end
    if (!ready_in) begin
      checks++; errors++;
      $display("FAIL beat_timeout ready_in=%b required 1", ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [BW-1:0] mask, input logic [7:0] b[$], input bit garbage);
    send_desc(mask);
    for (int unsigned i = 0; i < b.size(); i += BW) begin
      logic [DW-1:0] d;
      logic [BW-1:0] k;
      d = garbage ? $urandom : '0;
      k = '0;
      for (int unsigned j = 0; j < BW; j++) begin
        if (i + j < b.size()) begin
          d[DW-1-8*j -: 8] = b[i+j];
          k[BW-1-j] = 1'b1;
        end
      end
      send_beat(d, k, i + BW >= b.size());
    end
  endtask

  task automatic wait_out(input int unsigned cnt);
    int unsigned t = 0;
    while (cap_data.size() < cnt && t < 3000) begin @(posedge clk); t++; end
    if (cap_data.size() < cnt) begin
      checks++; errors++;
      $display("FAIL out_timeout beats=%0d required %0d", cap_data.size(), cnt);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (valid_out !== 0 || data_out !== 0 || keep_out !== 0 || last_out !== 0 ||
        ready_in !== 0 || ready_strip !== 0) begin
      errors++;
      $display("FAIL reset_outputs v=%b d=%h k=%b l=%b ri=%b rs=%b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_strip);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_strip !== 1 || valid_out !== 0 || ready_in !== 0) begin
      errors++;
      $display("FAIL reset_release rs=%b v=%b ri=%b required 1 0 0", ready_strip, valid_out, ready_in);
    end
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] ed[3];
    logic [BW-1:0] ek[3];
    logic          el[3];
    ed = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
    ek = '{4'b1111, 4'b1111, 4'b1111};
    el = '{1'b0, 1'b0, 1'b1};
    clear_q();
    send_desc(4'b0000);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    wait_out(3);
    checks++;
    if (cap_data.size() != 3) begin
      errors++; $display("FAIL n0_count beats=%0d required 3", cap_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= cap_data.size() || cap_data[i] !== ed[i] || cap_keep[i] !== ek[i] || cap_last[i] !== el[i]) begin
        errors++;
        $display("FAIL n0_beat%0d got %h/%b/%b required %h/%b/%b", i,
                 cap_data[i], cap_keep[i], cap_last[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_strip_tail();
    logic [DW-1:0] ed[3];
    logic [BW-1:0] ek[3];
    logic          el[3];
    ed = '{32'h02030405, 32'h06070809, 32'h0A0B0C00};
    ek = '{4'b1111, 4'b1111, 4'b1110};
    el = '{1'b0, 1'b0, 1'b1};
    clear_q();
    send_desc(4'b0001);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    send_beat(32'h090A0B0C, 4'b1111, 1'b1);
    checks++;
    if (ready_in !== 0) begin
      errors++; $display("FAIL n1_tail_ready_in got %b required 0", ready_in);
    end
    wait_out(3);
    checks++;
    if (cap_data.size() != 3) begin
      errors++; $display("FAIL n1_count beats=%0d required 3", cap_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= cap_data.size() || cap_data[i] !== ed[i] || cap_keep[i] !== ek[i] || cap_last[i] !== el[i]) begin
        errors++;
        $display("FAIL n1_beat%0d got %h/%b/%b required %h/%b/%b", i,
                 cap_data[i], cap_keep[i], cap_last[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_short_last();
    clear_q();
    send_desc(4'b0111);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060000, 4'b1100, 1'b1);
    wait_out(1);
    checks++;
    if (cap_data.size() != 1 || cap_data[0] !== 32'h04050600 || cap_keep[0] !== 4'b1110 || cap_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL n3_beat count=%0d got %h/%b/%b required 1 beat 04050600/1110/1",
               cap_data.size(), cap_data[0], cap_keep[0], cap_last[0]);
    end
  endtask

  task automatic test_drop();
    clear_q();
    send_desc(4'b0011);
    send_beat(32'h01020304, 4'b1100, 1'b1);
    checks++;
    if (ready_strip !== 1) begin
      errors++; $display("FAIL drop_ready_strip got %b required 1", ready_strip);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != 0) begin
      errors++; $display("FAIL drop_output beats=%0d required 0", cap_data.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] b[$];
    clear_q();
    for (int i = 1; i <= 16; i++) b.push_back(8'(i));
    model(1, b);
    fork
      send_pkt(4'b0001, b, 1'b0);
      begin
        logic [DW-1:0] hd;
        logic [BW-1:0] hk;
        logic          hl;
        int unsigned   t = 0;
        while (!valid_out && t < 300) begin @(posedge clk); #1; t++; end
        ready_out = 1'b0;
        hd = data_out; hk = keep_out; hl = last_out;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (valid_out !== 1 || data_out !== hd || keep_out !== hk || last_out !== hl || ready_in !== 0) begin
            errors++;
            $display("FAIL stall_hold v=%b d=%h k=%b l=%b ri=%b required 1 %h %b %b 0",
                     valid_out, data_out, keep_out, last_out, ready_in, hd, hk, hl);
          end
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    wait_out(exp_data.size());
    checks++;
    if (cap_data.size() != exp_data.size()) begin
      errors++; $display("FAIL stall_count beats=%0d required %0d", cap_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_keep[i] !== exp_keep[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL stall_beat%0d got %h/%b/%b required %h/%b/%b", i,
                 cap_data[i], cap_keep[i], cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    send_desc(4'b0001);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 0 || data_out !== 0 || keep_out !== 0 || last_out !== 0 ||
        ready_in !== 0 || ready_strip !== 0) begin
      errors++;
      $display("FAIL midrst_outputs v=%b d=%h k=%b l=%b ri=%b rs=%b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_strip);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    model(2, b);
    send_pkt(4'b0011, b, 1'b1);
    wait_out(exp_data.size());
    checks++;
    if (cap_data.size() != exp_data.size()) begin
      errors++; $display("FAIL midrst_count beats=%0d required %0d", cap_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_keep[i] !== exp_keep[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL midrst_beat%0d got %h/%b/%b required %h/%b/%b", i,
                 cap_data[i], cap_keep[i], cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    bp_en = 1'b1;
    for (int p = 0; p < 25; p++) begin
      logic [7:0]    b[$];
      logic [BW-1:0] m;
      int unsigned   n, len;
      n   = $urandom_range(0, BW);
      len = $urandom_range(1, 14);
      do m = BW'($urandom); while ($countones(m) != n);
      for (int unsigned i = 0; i < len; i++) b.push_back(8'($urandom));
      model(n, b);
      send_pkt(m, b, 1'b1);
    end
    wait_out(exp_data.size());
    bp_en = 1'b0;
    ready_out = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != exp_data.size()) begin
      errors++; $display("FAIL rand_count beats=%0d required %0d", cap_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (i >= cap_data.size() || cap_data[i] !== exp_data[i] || cap_keep[i] !== exp_keep[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL rand_beat%0d got %h/%b/%b required %h/%b/%b", i,
                 cap_data[i], cap_keep[i], cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b1;
    valid_strip = 1'b0; keep_strip = '0;
    test_reset();
    test_passthrough();
    test_strip_tail();
    test_short_last();
    test_drop();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data bus width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have the following ports, using one clock; reset is asynchronous and active-high:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  asynchronous active-high reset
  valid_in  in  1  input beat valid
  data_in  in  DATA_WD  input beat, byte 0 = data_in[DATA_WD-1 -: 8] (first on wire)
  keep_in  in  DATA_BYTE_WD  byte enables, keep_in[MSB] = byte 0; non-last beats all ones; last beat left-aligned, nonzero
  last_in  in  1  final beat of packet
  ready_in  out  1  input beat accepted when valid_in && ready_in
  valid_out  out  1  output beat valid
  data_out  out  DATA_WD  output beat, same byte order
  keep_out  out  DATA_BYTE_WD  output byte enables, left-aligned
  last_out  out  1  final output beat
  ready_out  in  1  downstream ready
  valid_strip  in  1  strip descriptor valid
  keep_strip  in  DATA_BYTE_WD  right-aligned mask; N = number of ones = header bytes to remove (0..DATA_BYTE_WD)
  ready_strip  out  1  descriptor accepted when valid_strip && ready_strip

Function
REQ-004 SHALL remove the first N bytes of each packet and emit the remaining bytes repacked: all output beats full except the last, which is left-aligned.
REQ-005 SHALL use FSM states IDLE, HEAD, BODY, TAIL; ready_strip = (state==IDLE) and deasserted while rst is high.
REQ-006 IDLE: descriptor handshake latches N, go HEAD; ready_in SHALL be 0 in IDLE and TAIL.
REQ-007 ready_in SHALL be 1 in HEAD/BODY when the output register is empty or ready_out is 1.
REQ-008 HEAD, non-last beat: store bytes N..DATA_BYTE_WD-1 left-aligned in a residual register, R = DATA_BYTE_WD-N, produce no output, go BODY.
REQ-009 HEAD, last beat with k valid bytes: if k>N emit one beat with k-N bytes, last_out=1; if k<=N drop the packet with no output; go IDLE.
REQ-010 BODY, non-last beat: emit full beat = R residual bytes followed by first DATA_BYTE_WD-R input bytes; residual becomes the last R input bytes; R constant per packet (R=0 passes beats through).
REQ-011 BODY, last beat with k bytes: if R+k<=DATA_BYTE_WD emit one beat with R+k bytes, last_out=1, go IDLE; else emit full beat last_out=0, keep R+k-DATA_BYTE_WD bytes in residual, go TAIL.
REQ-012 TAIL: emit residual as final beat with last_out=1 once output register frees, go IDLE.
REQ-013 Output SHALL be registered: latency exactly 1 cycle from accepting beat to valid_out; while valid_out && !ready_out, data_out/keep_out/last_out SHALL stay stable.
REQ-014 Invalid byte lanes of data_out SHALL be 0.
REQ-015 Descriptor offered during HEAD/BODY/TAIL SHALL wait (no acceptance) until IDLE.
REQ-016 Non-contiguous keep_strip SHALL be interpreted by popcount only.

Reset
REQ-017 rst SHALL immediately force state IDLE, valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, residual and N cleared, including mid-packet; partial packet discarded.

Structure
REQ-018 Shared package SHALL hold FSM state encoding, byte popcount function and default width constants.
REQ-019 One combinational sub-module axi_stream_byte_merge SHALL build output beat and next residual from residual, R and input beat.

Verification
REQ-020 N=0, beats AABBCCDD, 11223344, 55667788 (last keep 1111) -> identical 3 beats, last_out on third.
REQ-021 N=1, beats 01020304, 05060708, 090A0B0C last keep 1111 -> 02030405, 06070809 (keep 1111), then 0A0B0C00 keep 1110 last (via TAIL, ready_in low that cycle).
REQ-022 N=3, beats 01020304, 05060000 keep 1100 last -> single beat 04050600 keep 1110 last.
REQ-023 N=2, single beat 01020304 keep 1100 last -> no output, ready_strip high next cycle.
REQ-024 N=1 stream with ready_out low 3 cycles mid-packet -> ready_in low, output held stable, no byte lost or duplicated.
REQ-025 rst pulsed after second beat of packet -> valid_out 0 immediately, next packet after reset stripped correctly.
